// File: rtl/pixel_fifo.sv
// Pixel FIFO with tile-row loading, fine-scroll discard and object-row overlay.
// Background pixels enter TILE_W at a time; an object row can be merged onto the
// TILE_W head entries, and the head pixel is mixed combinationally for output.
module pixel_fifo #(
  parameter int DEPTH   = 16,
  parameter int TILE_W  = 8,
  parameter int COLOR_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [TILE_W*COLOR_W-1:0]   pixels_in,
  output logic                        load_ready,
  input  logic                        pull,
  output logic                        out_valid,
  output logic [COLOR_W-1:0]          out_color,
  output logic                        out_obj,
  output logic                        out_obj_pal,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        empty,
  output logic                        full,
  input  logic                        discard_start,
  input  logic [$clog2(TILE_W)-1:0]   discard_n,
  input  logic                        obj_merge,
  input  logic [TILE_W*COLOR_W-1:0]   obj_pixels,
  input  logic                        obj_pal,
  input  logic                        obj_bg_prio,
  output logic                        merge_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(TILE_W);

  // Per-entry storage: background color plus the object layer fields.
  logic [COLOR_W-1:0] bg_q   [DEPTH];
  logic [COLOR_W-1:0] obj_q  [DEPTH];
  logic               pal_q  [DEPTH];
  logic               prio_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] discard_left_q, discard_left_d;

  logic load_fire;
  logic merge_fire;
  logic drop;
  logic pop;

  logic [COLOR_W-1:0] head_bg;
  logic [COLOR_W-1:0] head_obj;

  // Readiness is judged on the current occupancy, so a pop in the same cycle
  // never makes room for a load.
  assign load_ready  = (CW'(DEPTH) - count_q) >= CW'(TILE_W);
  assign merge_ready = (count_q >= CW'(TILE_W)) && (discard_left_q == '0);
  assign load_fire   = load && load_ready;
  assign merge_fire  = obj_merge && merge_ready;
  assign drop        = (discard_left_q != '0) && (count_q != '0);

  // A merge owns the head entries for its cycle, so the head is not presented.
  assign out_valid   = (count_q != '0) && (discard_left_q == '0) && !merge_fire;
  assign pop         = pull && out_valid;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign head_bg     = bg_q[rd_ptr_q];
  assign head_obj    = obj_q[rd_ptr_q];
  assign out_obj_pal = pal_q[rd_ptr_q];

  // Layer mixing: an opaque object pixel wins unless it is behind a non-zero background.
  always_comb begin
    out_color = head_bg;
    out_obj   = 1'b0;
    if ((head_obj != '0) && (!prio_q[rd_ptr_q] || (head_bg == '0))) begin
      out_color = head_obj;
      out_obj   = 1'b1;
    end
  end

  // Next-state for pointers, occupancy and the pending discard count.
  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    discard_left_d = discard_left_q;
    if (pop || drop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_d - CW'(1);
    end
    if (load_fire) begin
      wr_ptr_d = wr_ptr_q + PW'(TILE_W);
      count_d  = count_d + CW'(TILE_W);
    end
    if (discard_start && (discard_n != '0)) begin
      discard_left_d = discard_n;
    end else if (drop) begin
      discard_left_d = discard_left_q - DW'(1);
    end
  end

  // State and entry updates; reset wipes every entry so the head is never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      discard_left_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bg_q[i]   <= '0;
        obj_q[i]  <= '0;
        pal_q[i]  <= 1'b0;
        prio_q[i] <= 1'b0;
      end
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      discard_left_q <= discard_left_d;
      if (load_fire) begin
        for (int i = 0; i < TILE_W; i++) begin
          bg_q[wr_ptr_q + PW'(i)]   <= pixels_in[i*COLOR_W +: COLOR_W];
          obj_q[wr_ptr_q + PW'(i)]  <= '0;
          pal_q[wr_ptr_q + PW'(i)]  <= 1'b0;
          prio_q[wr_ptr_q + PW'(i)] <= 1'b0;
        end
      end
      if (merge_fire) begin
        for (int i = 0; i < TILE_W; i++) begin
          if ((obj_q[rd_ptr_q + PW'(i)] == '0) &&
              (obj_pixels[i*COLOR_W +: COLOR_W] != '0)) begin
            obj_q[rd_ptr_q + PW'(i)]  <= obj_pixels[i*COLOR_W +: COLOR_W];
            pal_q[rd_ptr_q + PW'(i)]  <= obj_pal;
            prio_q[rd_ptr_q + PW'(i)] <= obj_bg_prio;
          end
        end
      end
    end
  end

endmodule
